// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester and APB bus signals for apb_master_arbiter.
// master modport (arbiter side):
//   in : req_i, addr_i, write_i, wdata_i, strb_i  - two requesters, packed per requester
//   in : pready_i, pslverr_i, prdata_i            - APB slave response
//   out: done_o, rdata_o, err_o                   - completion pulse and result
//   out: paddr_o, pport_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o - APB request
// slave modport: the mirror image, for whatever drives the requesters and the APB slave.
interface apb_master_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [1:0]                  req_i;
   logic [2*ADDR_WIDTH-1:0]     addr_i;
   logic [1:0]                  write_i;
   logic [2*DATA_WIDTH-1:0]     wdata_i;
   logic [2*DATA_WIDTH/8-1:0]   strb_i;
   logic [1:0]                  done_o;
   logic [DATA_WIDTH-1:0]       rdata_o;
   logic                        err_o;
   logic [ADDR_WIDTH-1:0]       paddr_o;
   logic [2:0]                  pport_o;
   logic                        psel_o;
   logic                        penable_o;
   logic                        pwrite_o;
   logic [DATA_WIDTH-1:0]       pwdata_o;
   logic [DATA_WIDTH/8-1:0]     pstrb_o;
   logic                        pready_i;
   logic                        pslverr_i;
   logic [DATA_WIDTH-1:0]       prdata_i;
   modport master (
      input  req_i, addr_i, write_i, wdata_i, strb_i, pready_i, pslverr_i, prdata_i,
      output done_o, rdata_o, err_o, paddr_o, pport_o, psel_o, penable_o, pwrite_o,
             pwdata_o, pstrb_o
   );
   modport slave (
      output req_i, addr_i, write_i, wdata_i, strb_i, pready_i, pslverr_i, prdata_i,
      input  done_o, rdata_o, err_o, paddr_o, pport_o, psel_o, penable_o, pwrite_o,
             pwdata_o, pstrb_o
   );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master with wait-state timeout.
// Ports:
//   pclk_i  - clock, rising edge
//   prstn_i - synchronous active-low reset
//   bus     - apb_master_arbiter_if.master: requester side (req/addr/write/wdata/strb in,
//             done/rdata/err out) and APB side (paddr/pport/psel/penable/pwrite/pwdata/pstrb
//             out, pready/pslverr/prdata in)
module apb_master_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TO_CYCLES  = 16
) (
   input logic                  pclk_i,
   input logic                  prstn_i,
   apb_master_arbiter_if.master bus
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = TO_CYCLES > 0 ? $clog2(TO_CYCLES + 1) : 1;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t                state_q;
   logic                  grant_q;
   logic                  last_q;
   logic [CW-1:0]         cnt_q;
   logic [1:0]            done_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic                  psel_q;
   logic                  penable_q;
   logic                  pwrite_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic [SW-1:0]         pstrb_q;
   logic                  pick_d;
   logic                  wr_d;
   logic                  timeout_d;
   // On a tie the requester not granted last wins; otherwise the lone requester wins.
   assign pick_d    = (&bus.req_i) ? ~last_q : bus.req_i[1];
   assign wr_d      = bus.write_i[pick_d];
   // Fires on the TO_CYCLES-th not-ready ACCESS cycle.
   assign timeout_d = (TO_CYCLES > 0) && (cnt_q == CW'(TO_CYCLES - 1));
   always_ff @(posedge pclk_i) begin
      if (!prstn_i) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         paddr_q   <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
      end else begin
         done_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               // A finishing requester still shows req_i during its done cycle.
               if (done_q == 2'b00 && bus.req_i != 2'b00) begin
                  grant_q   <= pick_d;
                  last_q    <= pick_d;
                  paddr_q   <= bus.addr_i[pick_d*ADDR_WIDTH +: ADDR_WIDTH];
                  pwrite_q  <= wr_d;
                  pwdata_q  <= wr_d ? bus.wdata_i[pick_d*DATA_WIDTH +: DATA_WIDTH] : '0;
                  pstrb_q   <= wr_d ? bus.strb_i[pick_d*SW +: SW] : '0;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (bus.pready_i || timeout_d) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  state_q   <= IDLE;
                  done_q    <= grant_q ? 2'b10 : 2'b01;
                  err_q     <= bus.pready_i ? bus.pslverr_i : 1'b1;
                  rdata_q   <= (bus.pready_i && !pwrite_q) ? bus.prdata_i : '0;
               end else if (TO_CYCLES > 0) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.done_o    = done_q;
   assign bus.rdata_o   = rdata_q;
   assign bus.err_o     = err_q;
   assign bus.paddr_o   = paddr_q;
   assign bus.pport_o   = 3'b000;
   assign bus.psel_o    = psel_q;
   assign bus.penable_o = penable_q;
   assign bus.pwrite_o  = pwrite_q;
   assign bus.pwdata_o  = pwdata_q;
   assign bus.pstrb_o   = pstrb_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: scoreboard bench for apb_master_arbiter; directed stimulus queues
// expected completions, a negedge monitor pops and compares them when done_o fires.
module tb_apb_master_arbiter;
   logic clk;
   logic rstn;
   int   passed;
   int   total;
   typedef struct {
      logic [1:0]  done;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;
   apb_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   apb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TO_CYCLES(16)) dut (
      .pclk_i (clk),
      .prstn_i(rstn),
      .bus    (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   always @(negedge clk) begin
      if (bus.done_o != 2'b00) begin
         if (q.size() == 0) check("unexpected_done", 64'(bus.done_o), 64'd0);
         else begin
            mon_e = q.pop_front();
            check("done_o", 64'(bus.done_o), 64'(mon_e.done));
            check("rdata_o", 64'(bus.rdata_o), 64'(mon_e.rdata));
            check("err_o", 64'(bus.err_o), 64'(mon_e.err));
         end
      end
   end
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   task automatic push(input logic [1:0] d, input logic [31:0] r, input logic e);
      exp_t x;
      x.done  = d;
      x.rdata = r;
      x.err   = e;
      q.push_back(x);
   endtask
   task automatic wait_done(input string name, output int k);
      k = 0;
      do begin
         tick();
         k++;
      end while (bus.done_o == 2'b00 && k < 60);
      check({name, "_done_seen"}, 64'(bus.done_o != 2'b00), 64'd1);
   endtask
   task automatic check_all_zero(input string name);
      check({name, "_ctl"}, 64'({bus.done_o, bus.err_o, bus.psel_o, bus.penable_o,
                                 bus.pwrite_o, bus.pport_o, bus.pstrb_o}), 64'd0);
      check({name, "_paddr"}, 64'(bus.paddr_o), 64'd0);
      check({name, "_data"}, {bus.rdata_o, bus.pwdata_o}, 64'd0);
   endtask
   initial begin
      int k;
      int acc;
      passed = 0;
      total  = 0;
      rstn = 1'b0;
      bus.req_i = 2'b00;
      bus.addr_i = '0;
      bus.write_i = 2'b00;
      bus.wdata_i = '0;
      bus.strb_i = '0;
      bus.pready_i = 1'b0;
      bus.pslverr_i = 1'b0;
      bus.prdata_i = '0;
      tick();
      tick();
      check_all_zero("reset");
      rstn = 1'b1;
      // single write from requester 0
      tick();
      bus.req_i = 2'b01;
      bus.addr_i[31:0] = 32'h100;
      bus.write_i = 2'b01;
      bus.wdata_i[31:0] = 32'hA5A5A5A5;
      bus.strb_i[3:0] = 4'hF;
      bus.pready_i = 1'b1;
      push(2'b01, 32'h0, 1'b0);
      tick();
      check("wr_setup_sel_en", 64'({bus.psel_o, bus.penable_o}), 64'b10);
      check("wr_setup_addr", 64'(bus.paddr_o), 64'h100);
      check("wr_setup_wr_data_strb", {27'd0, bus.pwrite_o, bus.pwdata_o, bus.pstrb_o},
            {27'd0, 1'b1, 32'hA5A5A5A5, 4'hF});
      tick();
      check("wr_access_sel_en", 64'({bus.psel_o, bus.penable_o}), 64'b11);
      tick();
      check("wr_done_cycle", 64'(bus.done_o), 64'b01);
      check("wr_done_sel_en", 64'({bus.psel_o, bus.penable_o}), 64'b00);
      bus.req_i = 2'b00;
      // read from requester 1 with three wait states
      tick();
      bus.req_i = 2'b10;
      bus.addr_i[63:32] = 32'h200;
      bus.write_i = 2'b00;
      bus.wdata_i[63:32] = 32'hDEADBEEF;
      bus.strb_i[7:4] = 4'hF;
      bus.pready_i = 1'b0;
      push(2'b10, 32'h12345678, 1'b0);
      tick();
      check("rd_setup", {bus.paddr_o, 26'd0, bus.psel_o, bus.penable_o, bus.pwrite_o,
                         bus.pstrb_o[2:0]}, {32'h200, 26'd0, 3'b100, 3'b000});
      check("rd_setup_zero_wdata_strb", 64'({bus.pwdata_o, bus.pstrb_o}), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rd_access_%0d", i), 64'({bus.psel_o, bus.penable_o, bus.pstrb_o}),
               64'({2'b11, 4'h0}));
         if (i == 3) begin
            bus.pready_i = 1'b1;
            bus.prdata_i = 32'h12345678;
         end
      end
      wait_done("rd", k);
      check("rd_done_latency", 64'(k), 64'd1);
      bus.req_i = 2'b00;
      bus.prdata_i = '0;
      // slave error on a write
      tick();
      bus.req_i = 2'b10;
      bus.write_i = 2'b10;
      bus.pready_i = 1'b1;
      bus.pslverr_i = 1'b1;
      push(2'b10, 32'h0, 1'b1);
      wait_done("slverr", k);
      check("slverr_latency", 64'(k), 64'd3);
      bus.req_i = 2'b00;
      bus.pslverr_i = 1'b0;
      // timeout on a read with pready held low
      tick();
      bus.req_i = 2'b01;
      bus.write_i = 2'b00;
      bus.pready_i = 1'b0;
      bus.prdata_i = 32'hFFFFFFFF;
      push(2'b01, 32'h0, 1'b1);
      acc = 0;
      k = 0;
      do begin
         tick();
         k++;
         if (bus.penable_o) acc++;
      end while (bus.done_o == 2'b00 && k < 60);
      check("to_access_cycles", 64'(acc), 64'd16);
      check("to_sel_after", 64'(bus.psel_o), 64'd0);
      bus.req_i = 2'b00;
      bus.prdata_i = '0;
      // contention from reset: expect 0,1,0,1
      tick();
      rstn = 1'b0;
      bus.req_i = 2'b11;
      bus.write_i = 2'b01;
      bus.pready_i = 1'b1;
      bus.prdata_i = 32'hCAFE0001;
      tick();
      rstn = 1'b1;
      push(2'b01, 32'h0, 1'b0);
      push(2'b10, 32'hCAFE0001, 1'b0);
      push(2'b01, 32'h0, 1'b0);
      push(2'b10, 32'hCAFE0001, 1'b0);
      k = 0;
      while (q.size() != 0 && k < 60) begin
         tick();
         k++;
      end
      bus.req_i = 2'b00;
      check("rr_drained", 64'(q.size()), 64'd0);
      check("rr_cycles", 64'(k), 64'd15);
      // reset while in ACCESS, then a normal transfer
      tick();
      tick();
      bus.req_i = 2'b01;
      bus.write_i = 2'b01;
      bus.addr_i[31:0] = 32'h300;
      bus.pready_i = 1'b0;
      tick();
      tick();
      check("rst_mid_in_access", 64'({bus.psel_o, bus.penable_o}), 64'b11);
      rstn = 1'b0;
      bus.req_i = 2'b00;
      tick();
      check_all_zero("rst_mid");
      rstn = 1'b1;
      bus.req_i = 2'b01;
      bus.pready_i = 1'b1;
      push(2'b01, 32'h0, 1'b0);
      wait_done("post_rst", k);
      check("post_rst_latency", 64'(k), 64'd3);
      bus.req_i = 2'b00;
      tick();
      tick();
      check("final_queue_empty", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
